// File: rtl/division_seq_nd.sv
// rtl/division_seq_nd.sv - iterative restoring fixed-point divider, one quotient bit per clock
// Signed operands are divided as magnitudes; signs are reapplied in FIX.
module division_seq_nd #(
  parameter int N     = 32,
  parameter int DIGIT = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 signed_i,
  input  logic [N-1:0]         data0_i,
  input  logic [N-1:0]         data1_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [N+DIGIT-1:0]   y_o,
  output logic [N-1:0]         rem_o,
  output logic                 dz_o,
  output logic                 ovf_o
);

  localparam int Q  = N + DIGIT;
  localparam int CW = $clog2(Q + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(Q - 1);
  localparam logic [Q-1:0]  Y_MAX    = {1'b0, {(Q-1){1'b1}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_DONE} state_t;

  state_t         state;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic           mode_r;
  logic           q_neg;
  logic           r_neg;
  logic           dz_r;
  logic [N-1:0]   b_mag;
  logic [N-1:0]   pr;
  logic [Q-1:0]   sh;
  logic [Q-1:0]   q;
  logic [CW-1:0]  cnt;

  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   a_mag_w;
  logic [N-1:0]   b_mag_w;
  logic [N:0]     pr_sh;
  logic           take;
  logic [N-1:0]   pr_nxt;
  logic [Q-1:0]   q_fin;
  logic [N-1:0]   r_fin;
  logic           ovf_w;

  // An N-bit unsigned magnitude already holds 2^(N-1), so -2^(N-1) negates cleanly.
  // The shifted partial remainder needs N+1 bits; its top bit forces a subtract.
  always_comb begin
    a_neg   = mode_r & a_r[N-1];
    b_neg   = mode_r & b_r[N-1];
    a_mag_w = a_neg ? -a_r : a_r;
    b_mag_w = b_neg ? -b_r : b_r;
    pr_sh   = {pr, sh[Q-1]};
    take    = pr_sh[N] | (pr_sh[N-1:0] >= b_mag);
    pr_nxt  = take ? (pr_sh[N-1:0] - b_mag) : pr_sh[N-1:0];
    q_fin   = q_neg ? -q : q;
    r_fin   = r_neg ? -pr : pr;
    ovf_w   = mode_r & ~q_neg & q[Q-1];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      mode_r  <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz_r    <= 1'b0;
      b_mag   <= '0;
      pr      <= '0;
      sh      <= '0;
      q       <= '0;
      cnt     <= '0;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      y_o     <= '0;
      rem_o   <= '0;
      dz_o    <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            a_r     <= data0_i;
            b_r     <= data1_i;
            mode_r  <= signed_i;
            valid_o <= 1'b0;
            dz_o    <= 1'b0;
            ovf_o   <= 1'b0;
            busy_o  <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          q_neg <= a_neg ^ b_neg;
          r_neg <= a_neg;
          b_mag <= b_mag_w;
          sh    <= {a_mag_w, {DIGIT{1'b0}}};
          pr    <= '0;
          q     <= '0;
          cnt   <= CNT_LAST;
          dz_r  <= (b_r == '0);
          state <= (b_r == '0) ? S_FIX : S_CALC;
        end
        S_CALC: begin
          sh <= sh << 1;
          pr <= pr_nxt;
          q  <= {q[Q-2:0], take};
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          if (dz_r) begin
            y_o   <= '1;
            rem_o <= a_r;
            dz_o  <= 1'b1;
          end else if (ovf_w) begin
            y_o   <= Y_MAX;
            rem_o <= r_fin;
            ovf_o <= 1'b1;
          end else begin
            y_o   <= q_fin;
            rem_o <= r_fin;
          end
          valid_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_division_seq_nd.sv
// tb/tb_division_seq_nd.sv - self-checking bench for division_seq_nd (N=8, DIGIT=4)
module tb_division_seq_nd;

  localparam int N     = 8;
  localparam int DIGIT = 4;
  localparam int Q     = N + DIGIT;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [N-1:0] d0 = '0;
  logic [N-1:0] d1 = '0;
  logic         busy;
  logic         valid;
  logic [Q-1:0] y;
  logic [N-1:0] rem;
  logic         dz;
  logic         ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  division_seq_nd #(.N(N), .DIGIT(DIGIT)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (start),
    .signed_i(sgn),
    .data0_i (d0),
    .data1_i (d1),
    .busy_o  (busy),
    .valid_o (valid),
    .y_o     (y),
    .rem_o   (rem),
    .dz_o    (dz),
    .ovf_o   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         s;
    logic [Q-1:0] ey;
    logic [N-1:0] er;
    logic         edz;
    logic         eovf;
    int           elat;
  } vec_t;

  // Reference: plain integer arithmetic on the scaled dividend.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                                output logic [Q-1:0] ey, output logic [N-1:0] er,
                                output logic edz, output logic eovf, output int elat);
    longint sa, sb, na, nb, qq, rr;
    edz = 1'b0; eovf = 1'b0;
    if (b == '0) begin
      ey = '1; er = a; edz = 1'b1; elat = 2;
      return;
    end
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    na = (sa < 0 ? -sa : sa) * (longint'(1) << DIGIT);
    nb = (sb < 0 ? -sb : sb);
    qq = na / nb;
    rr = na % nb;
    if ((sa < 0) != (sb < 0)) qq = -qq;
    if (sa < 0) rr = -rr;
    if (s && qq > (longint'(1) << (Q - 1)) - 1) begin
      ey = {1'b0, {(Q-1){1'b1}}};
      eovf = 1'b1;
    end else begin
      ey = Q'(qq);
    end
    er = N'(rr);
    elat = Q + 2;
  endfunction

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    @(negedge clk);
    d0 = a; d1 = b; sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int from, output int lat);
    bit seen = 1'b0;
    lat = -1;
    for (int c = from + 1; c <= from + 40 && !seen; c++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        lat = c;
        seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL reset valid got %b exp 0", valid); else pass_cnt++;
    total_cnt++; if (y !== '0) $display("FAIL reset y got %h exp 000", y); else pass_cnt++;
    total_cnt++; if (rem !== '0) $display("FAIL reset rem got %h exp 00", rem); else pass_cnt++;
    total_cnt++; if (dz !== 1'b0) $display("FAIL reset dz got %b exp 0", dz); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL reset ovf got %b exp 0", ovf); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v[7];
    int lat;
    v[0] = '{8'd100, 8'd7,  1'b0, 12'h0E4, 8'h04, 1'b0, 1'b0, 14};
    v[1] = '{8'h9C,  8'h07, 1'b1, 12'hF1C, 8'hFC, 1'b0, 1'b0, 14};
    v[2] = '{8'h64,  8'hF9, 1'b1, 12'hF1C, 8'h04, 1'b0, 1'b0, 14};
    v[3] = '{8'h05,  8'h00, 1'b0, 12'hFFF, 8'h05, 1'b1, 1'b0, 2};
    v[4] = '{8'h05,  8'h00, 1'b1, 12'hFFF, 8'h05, 1'b1, 1'b0, 2};
    v[5] = '{8'h80,  8'hFF, 1'b1, 12'h7FF, 8'h00, 1'b0, 1'b1, 14};
    v[6] = '{8'h80,  8'hFF, 1'b0, 12'h008, 8'h08, 1'b0, 1'b0, 14};
    for (int i = 0; i < 7; i++) begin
      start_op(v[i].a, v[i].b, v[i].s);
      total_cnt++; if (busy !== 1'b1) $display("FAIL dir%0d busy got %b exp 1", i, busy); else pass_cnt++;
      wait_valid(0, lat);
      total_cnt++; if (lat != v[i].elat) $display("FAIL dir%0d latency got %0d exp %0d", i, lat, v[i].elat); else pass_cnt++;
      total_cnt++; if (y !== v[i].ey) $display("FAIL dir%0d y got %h exp %h", i, y, v[i].ey); else pass_cnt++;
      total_cnt++; if (rem !== v[i].er) $display("FAIL dir%0d rem got %h exp %h", i, rem, v[i].er); else pass_cnt++;
      total_cnt++; if (dz !== v[i].edz) $display("FAIL dir%0d dz got %b exp %b", i, dz, v[i].edz); else pass_cnt++;
      total_cnt++; if (ovf !== v[i].eovf) $display("FAIL dir%0d ovf got %b exp %b", i, ovf, v[i].eovf); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL dir%0d done busy got %b exp 0", i, busy); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    logic s;
    logic [Q-1:0] ey;
    logic [N-1:0] er;
    logic edz, eovf;
    int elat, lat;
    for (int i = 0; i < 30; i++) begin
      a = N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      s = 1'($urandom);
      model(a, b, s, ey, er, edz, eovf, elat);
      start_op(a, b, s);
      wait_valid(0, lat);
      total_cnt++; if (lat != elat) $display("FAIL rnd%0d latency got %0d exp %0d", i, lat, elat); else pass_cnt++;
      total_cnt++; if (y !== ey) $display("FAIL rnd%0d y %h/%h s=%b got %h exp %h", i, a, b, s, y, ey); else pass_cnt++;
      total_cnt++; if (rem !== er) $display("FAIL rnd%0d rem %h/%h s=%b got %h exp %h", i, a, b, s, rem, er); else pass_cnt++;
      total_cnt++; if ({dz, ovf} !== {edz, eovf}) $display("FAIL rnd%0d flags got %b%b exp %b%b", i, dz, ovf, edz, eovf); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(8'd100, 8'd7, 1'b0);
    repeat (4) @(negedge clk);
    d0 = 8'd3; d1 = 8'd200; sgn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(5, lat);
    total_cnt++; if (lat != Q + 2) $display("FAIL ignore latency got %0d exp %0d", lat, Q + 2); else pass_cnt++;
    total_cnt++; if (y !== 12'h0E4) $display("FAIL ignore y got %h exp 0e4", y); else pass_cnt++;
    total_cnt++; if (rem !== 8'h04) $display("FAIL ignore rem got %h exp 04", rem); else pass_cnt++;
    d0 = 8'h9C; d1 = 8'h07; sgn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++; if (valid !== 1'b0) $display("FAIL b2b valid drop got %b exp 0", valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b busy got %b exp 1", busy); else pass_cnt++;
    wait_valid(0, lat);
    total_cnt++; if (lat != Q + 2) $display("FAIL b2b latency got %0d exp %0d", lat, Q + 2); else pass_cnt++;
    total_cnt++; if (y !== 12'hF1C) $display("FAIL b2b y got %h exp f1c", y); else pass_cnt++;
    total_cnt++; if (rem !== 8'hFC) $display("FAIL b2b rem got %h exp fc", rem); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat;
    start_op(8'd50, 8'd3, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (valid !== 1'b0) $display("FAIL midrst valid got %b exp 0", valid); else pass_cnt++;
    total_cnt++; if (y !== '0) $display("FAIL midrst y got %h exp 000", y); else pass_cnt++;
    total_cnt++; if (rem !== '0) $display("FAIL midrst rem got %h exp 00", rem); else pass_cnt++;
    total_cnt++; if ({dz, ovf} !== 2'b00) $display("FAIL midrst flags got %b%b exp 00", dz, ovf); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total_cnt++; if (valid !== 1'b0) $display("FAIL midrst stale valid got %b exp 0", valid); else pass_cnt++;
    start_op(8'd200, 8'd3, 1'b0);
    wait_valid(0, lat);
    total_cnt++; if (lat != Q + 2) $display("FAIL post latency got %0d exp %0d", lat, Q + 2); else pass_cnt++;
    total_cnt++; if (y !== 12'h42A) $display("FAIL post y got %h exp 42a", y); else pass_cnt++;
    total_cnt++; if (rem !== 8'h02) $display("FAIL post rem got %h exp 02", rem); else pass_cnt++;
    total_cnt++; if ({dz, ovf} !== 2'b00) $display("FAIL post flags got %b%b exp 00", dz, ovf); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/division_seq_nd.md
Name: division_seq_nd

Overview:
- Parametrised iterative restoring divider.
- Computes (dividend << DIGIT) / divisor, producing N integer bits plus DIGIT fractional quotient bits, one quotient bit per clock.
- Successor to the fixed-width fractional divider:
  - start/valid handshake;
  - run-time signed/unsigned mode;
  - remainder output;
  - divide-by-zero and overflow flags.
- Sits in the arithmetic library, used by datapaths needing fixed-point ratios.

Parameters:
- N, 32, integer width of dividend, divisor and remainder.
- DIGIT, 32, number of fractional quotient bits.
- Derived, not overridable:
  - Q = N+DIGIT, quotient width;
  - CW = clog2(Q+1), iteration counter width.

Ports:
- clk_i  in  1  clock, rising-edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request; accepted only in IDLE or DONE.
- signed_i  in  1  1 = two's-complement operands; 0 = unsigned. Sampled at accept.
- data0_i  in  N  dividend, sampled at accept.
- data1_i  in  N  divisor, sampled at accept.
- busy_o  out  1  high while the operation is in LOAD/CALC/FIX.
- valid_o  out  1  result valid; level, held until the next accepted start.
- y_o  out  Q  quotient, fixed point: N integer bits . DIGIT fraction bits.
- rem_o  out  N  remainder of (|dividend|<<DIGIT) mod |divisor|, carrying the dividend's sign.
- dz_o  out  1  divide-by-zero flag, qualified by valid_o.
- ovf_o  out  1  signed overflow flag, qualified by valid_o.

Behaviour:
- Reset (rst_i low, asynchronous): FSM goes to IDLE. busy_o, valid_o, y_o, rem_o, dz_o and ovf_o all go to 0; counter goes to 0.
- FSM states: IDLE, LOAD, CALC, FIX, DONE.
- Accept: start_i=1 in IDLE or DONE.
  - Latch operands and mode; clear valid_o, dz_o and ovf_o; go to LOAD.
  - start_i in LOAD/CALC/FIX is ignored; no effect on the running operation.
- LOAD (1 cycle):
  - Form magnitudes in N+1 bits, so -2^(N-1) is representable.
  - Record quotient sign = sign(a) xor sign(b) and remainder sign = sign(a). Signs are 0 when signed_i=0.
  - If divisor == 0: go to FIX directly with dz flagged.
  - Otherwise load partial remainder = 0, counter = Q-1, go to CALC.
- CALC (exactly Q cycles, MSB first):
  - Shift the next bit of (|a|<<DIGIT) into the partial remainder.
  - If partial remainder >= |b|: subtract and set y[counter]=1; else y[counter]=0.
  - When counter reaches 0, go to FIX. Otherwise decrement.
  - Partial remainder is N+1 bits wide; no bit may be lost.
- FIX (1 cycle):
  - Apply quotient and remainder signs (two's-complement negate).
  - Overflow: signed mode, positive result > 2^(Q-1)-1 (only -2^(N-1) / -1). Then y_o = 2^(Q-1)-1 and ovf_o = 1.
  - Divide by zero: y_o = all ones (Q bits), rem_o = raw dividend, dz_o = 1.
  - Go to DONE; valid_o = 1.
- DONE: holds all outputs stable; busy_o = 0. A new start is accepted here; valid_o drops the following cycle.
- Latency, start accept edge to valid_o high:
  - normal: Q+2 cycles;
  - divide-by-zero: 2 cycles.
- Throughput: back-to-back start in DONE is allowed; no idle gap is required.
- Unsigned mode: the operand MSB is magnitude; no negation; ovf_o is never set.
- Reset mid-operation: aborts immediately; no partial result is ever flagged valid.

Test Plan:
All cases use N=8, DIGIT=4, so Q=12.
1. Unsigned 100/7 -> valid_o 14 cycles after accept; y_o=0x0E4 (228 = 14.25), rem_o=4, dz_o=0, ovf_o=0.
2. Signed -100/7 (0x9C / 0x07) -> y_o=0xF1C (-228), rem_o=0xFC (-4). Repeat as 100/-7 -> y_o=0xF1C, rem_o=0x04.
3. Divide by zero 5/0, both modes -> valid_o 2 cycles after accept; dz_o=1, y_o=0xFFF, rem_o=0x05.
4. Signed -128/-1 -> ovf_o=1, y_o=0x7FF. The same operands unsigned (128/255) -> y_o=0x008, rem_o=0x08, ovf_o=0.
5. start_i pulsed with new operands mid-CALC -> ignored; original result correct at the expected cycle. Then a start in DONE the cycle valid_o rises -> valid_o low next cycle, second result after a further Q+2 cycles.
6. rst_i asserted low at CALC cycle 5 -> all outputs 0 asynchronously. After release, a fresh 200/3 unsigned -> y_o=0x42A (1066), rem_o=2.
